// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction fetch stage of the 16-bit RISC core.
// Drives the PC unit (hold/increment/load/clear), issues one instruction-memory
// read per cycle while queue space allows, and buffers returned words together
// with their addresses for decode. Redirect/restart flush the queue and kill
// the in-flight read.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   pc_out                current PC from the PC unit
//   pc_counter            PC command: 00 hold, 01 inc, 10 load pc_target, 11 clear
//   pc_target             load value for the PC unit
//   imem_req/imem_addr    instruction memory read strobe and address
//   imem_rdata            read data, valid one cycle after imem_req
//   redirect/redirect_pc  taken branch/jump from execute and its target
//   restart               restart program from address 0
//   inst_valid/inst_ready head-entry handshake with decode
//   inst_word/inst_pc     head instruction word and its address
//   q_count               occupied queue entries
//
// Optional feature: define FETCH_BYPASS_EN to present a response directly to
// decode in its arrival cycle when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       pc_out,
  output logic [1:0]              pc_counter,
  output logic [ADDR_W-1:0]       pc_target,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [DATA_W-1:0]       imem_rdata,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  input  logic                    restart,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [DATA_W-1:0]       inst_word,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  localparam logic [1:0] PC_HOLD  = 2'b00;
  localparam logic [1:0] PC_INC   = 2'b01;
  localparam logic [1:0] PC_LOAD  = 2'b10;
  localparam logic [1:0] PC_CLEAR = 2'b11;

  // Queue storage and control state
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_word [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pending;
  logic [ADDR_W-1:0] pending_pc;

  logic              flush;
  logic              issue;
  logic              resp;
  logic              has_data;
  logic              push;
  logic              pop;
  logic [OCC_W-1:0]  occ;

  assign flush    = restart | redirect;
  assign has_data = (count != '0);
  // Returning data is only kept if no flush happens in its arrival cycle.
  assign resp     = pending & ~flush;
  // Committed occupancy: stored entries plus the read already in flight.
  assign occ      = OCC_W'(count) + OCC_W'(pending);
  assign issue    = ~rst & ~flush & (occ < OCC_W'(DEPTH));

  // PC unit command and memory request
  always_comb begin
    pc_counter = PC_HOLD;
    pc_target  = '0;
    imem_req   = 1'b0;
    imem_addr  = pc_out;
    if (rst) begin
      pc_counter = PC_HOLD;
    end else if (restart) begin
      pc_counter = PC_CLEAR;
    end else if (redirect) begin
      pc_counter = PC_LOAD;
      pc_target  = redirect_pc;
    end else if (issue) begin
      pc_counter = PC_INC;
      imem_req   = 1'b1;
    end
  end

`ifdef FETCH_BYPASS_EN
  logic byp;
  logic byp_taken;

  // Empty queue: the arriving response goes straight to decode.
  assign byp       = ~has_data & resp;
  assign byp_taken = byp & inst_ready;

  // Decode-side view: queue head, else the bypassed response
  always_comb begin
    inst_valid = (has_data | resp) & ~flush;
    inst_word  = '0;
    inst_pc    = '0;
    if (has_data) begin
      inst_word = q_word[rd_ptr];
      inst_pc   = q_pc[rd_ptr];
    end else if (byp) begin
      inst_word = imem_rdata;
      inst_pc   = pending_pc;
    end
  end

  assign push = resp & ~byp_taken;
`else
  // Decode-side view: queue head; zero while empty so reset shows 0
  always_comb begin
    inst_valid = has_data & ~flush;
    inst_word  = '0;
    inst_pc    = '0;
    if (has_data) begin
      inst_word = q_word[rd_ptr];
      inst_pc   = q_pc[rd_ptr];
    end
  end

  assign push = resp;
`endif

  assign pop     = inst_valid & inst_ready & has_data;
  assign q_count = count;

  // Pointers, occupancy and in-flight read tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= pc_out;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while counted as occupied
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pending_pc;
      q_word[wr_ptr] <= imem_rdata;
    end
  end

  // The issue rule must keep occupancy within DEPTH
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scoreboard bench for inst_fetch_queue. Models the PC
// unit and an instruction memory returning addr+16'h1000 one cycle after a
// request; expected {pc, word} pairs are queued by the stimulus and checked by
// a monitor on every accepted handshake.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_out;
  logic [1:0]        pc_counter;
  logic [ADDR_W-1:0] pc_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              restart;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic [2:0]        q_count;

  int   checks    = 0;
  int   failures  = 0;
  int   accepted  = 0;
  int   req_count = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] pc_reg;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_counter(pc_counter),
    .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .restart(restart), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_pc(inst_pc), .q_count(q_count)
  );

  // PC unit model
  always @(posedge clk or posedge rst) begin
    if (rst) pc_reg <= 16'h0000;
    else begin
      case (pc_counter)
        2'b01:   pc_reg <= pc_reg + 16'h0001;
        2'b10:   pc_reg <= pc_target;
        2'b11:   pc_reg <= 16'h0000;
        default: pc_reg <= pc_reg;
      endcase
    end
  end
  assign pc_out = pc_reg;

  // Instruction memory model: one-cycle read latency
  always @(posedge clk) begin
    imem_rdata <= imem_req ? 16'(imem_addr + 16'h1000) : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({16'(start + 16'(i)), 16'(start + 16'(i) + 16'h1000)});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every accepted instruction
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      accepted++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %0h word %0h, expected no instruction", inst_pc, inst_word);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", 32'(inst_pc), 32'(mon_e.pc));
        check("sb_word", 32'(inst_word), 32'(mon_e.word));
      end
    end
    if (!rst && imem_req) req_count++;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; restart = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_pc_counter", 32'(pc_counter), 0);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_inst_word", 32'(inst_word), 0);
    check("rst_inst_pc", 32'(inst_pc), 0);
    check("rst_q_count", 32'(q_count), 0);

    // Streaming with decode always ready
    cyc();
    rst = 1'b0; inst_ready = 1'b1;
    push_exp(16'h0000, 16);
    @(negedge clk);
    check("c0_imem_req", 32'(imem_req), 1);
    check("c0_imem_addr", 32'(imem_addr), 0);
    check("c0_pc_counter", 32'(pc_counter), 1);
    check("c0_inst_valid", 32'(inst_valid), 0);
    cyc();
    @(negedge clk);
    check("c1_inst_valid", 32'(inst_valid), 32'(BYP));
    cyc();
    @(negedge clk);
    check("c2_inst_valid", 32'(inst_valid), 1);
    repeat (10) cyc();
    check("p1_throughput", 32'(accepted), 32'(10 + BYP));
    check("p1_q_count", 32'(q_count), 32'(1 - BYP));

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc_counter", 32'(pc_counter), 0);
    check("arst_imem_req", 32'(imem_req), 0);
    check("arst_inst_valid", 32'(inst_valid), 0);
    check("arst_q_count", 32'(q_count), 0);
    check("arst_inst_word", 32'(inst_word), 0);
    check("arst_inst_pc", 32'(inst_pc), 0);
    exp_q.delete();
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    accepted = 0;
    req_count = 0;
    push_exp(16'h0000, 16);

    // Decode stalled: queue fills to DEPTH then fetch holds
    repeat (8) cyc();
    check("full_q_count", 32'(q_count), 4);
    check("full_req_count", 32'(req_count), 4);
    check("full_pc_out", 32'(pc_out), 4);
    check("full_imem_req", 32'(imem_req), 0);
    check("full_pc_counter", 32'(pc_counter), 0);
    check("full_accepted", 32'(accepted), 0);
    inst_ready = 1'b1;
    #1;
    check("d0_no_pop_credit", 32'(pc_counter), 0);
    check("d0_inst_valid", 32'(inst_valid), 1);
    cyc();
    check("d1_pc_counter", 32'(pc_counter), 1);
    check("d1_imem_addr", 32'(imem_addr), 4);
    repeat (9) cyc();
    check("drain_accepted", 32'(accepted), 10);

    // Restart, refill to 3 entries + 1 in flight, then redirect
    inst_ready = 1'b0;
    restart = 1'b1;
    #1;
    check("rs_pc_counter", 32'(pc_counter), 3);
    check("rs_inst_valid", 32'(inst_valid), 0);
    check("rs_imem_req", 32'(imem_req), 0);
    cyc();
    restart = 1'b0;
    exp_q.delete();
    repeat (4) cyc();
    check("pre_redir_q_count", 32'(q_count), 3);
    check("pre_redir_imem_req", 32'(imem_req), 0);
    redirect = 1'b1; redirect_pc = 16'h0040;
    #1;
    check("redir_pc_counter", 32'(pc_counter), 2);
    check("redir_pc_target", 32'(pc_target), 32'h40);
    check("redir_inst_valid", 32'(inst_valid), 0);
    check("redir_imem_req", 32'(imem_req), 0);
    cyc();
    redirect = 1'b0;
    push_exp(16'h0040, 16);
    #1;
    check("f0_q_count", 32'(q_count), 0);
    check("f0_pc_out", 32'(pc_out), 32'h40);
    check("f0_imem_addr", 32'(imem_addr), 32'h40);
    check("f0_imem_req", 32'(imem_req), 1);
    check("f0_inst_valid", 32'(inst_valid), 0);
    cyc();
    check("f1_inst_valid", 32'(inst_valid), 32'(BYP));
    cyc();
    check("f2_inst_valid", 32'(inst_valid), 1);
    check("f2_inst_pc", 32'(inst_pc), 32'h40);
    inst_ready = 1'b1;
    repeat (5) cyc();

    // Simultaneous restart and redirect: restart wins
    restart = 1'b1; redirect = 1'b1; redirect_pc = 16'h0077;
    #1;
    check("both_pc_counter", 32'(pc_counter), 3);
    check("both_inst_valid", 32'(inst_valid), 0);
    cyc();
    restart = 1'b0; redirect = 1'b0;
    exp_q.delete();
    accepted = 0;
    push_exp(16'h0000, 16);
    check("both_pc_out", 32'(pc_out), 0);
    repeat (12) cyc();
    check("both_accepted", 32'(accepted), 32'(10 + BYP));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage sitting directly downstream of the program counter unit in the 16-bit RISC core. It commands the PC unit (hold/increment/load/clear), issues instruction-memory reads at the current PC, and buffers returned instruction words with their addresses in a small queue feeding decode over a valid/ready handshake. Branch redirects and restarts from execute flush the queue and kill any in-flight read.

## Interface
- DEPTH, 4: queue entries, power of two, 2..16
- ADDR_W, 16: PC / instruction address width
- DATA_W, 16: instruction word width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pc_out  in  ADDR_W  current PC from the PC unit
- pc_counter  out  2  PC command: 00 hold, 01 increment, 10 load pc_target, 11 clear to 0
- pc_target  out  ADDR_W  load value for the PC unit (pc_in)
- imem_req  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address (= pc_out)
- imem_rdata  in  DATA_W  read data, valid exactly one cycle after imem_req
- redirect  in  1  branch/jump taken in execute
- redirect_pc  in  ADDR_W  branch target
- restart  in  1  restart program from address 0
- inst_valid  out  1  head entry valid for decode
- inst_ready  in  1  decode accepts head entry
- inst_word  out  DATA_W  head instruction word
- inst_pc  out  ADDR_W  address of inst_word
- q_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: circular queue of {pc, word}, rd/wr pointers, count; pending flag + pending_pc for the one in-flight read.
- Per-cycle priority: rst > restart > redirect > issue/hold.
- restart: pc_counter=11; queue flushed (count=0, pointers=0); pending cleared; imem_req=0; inst_valid forced 0.
- redirect (no restart): pc_counter=10, pc_target=redirect_pc; same flush/kill as restart; imem_req=0; inst_valid forced 0.
- Issue when count + pending < DEPTH: imem_req=1, imem_addr=pc_out, pc_counter=01; pending set, pending_pc=pc_out at clock edge.
- Otherwise pc_counter=00, imem_req=0, pending cleared at edge.
- Response: if pending was set last cycle, imem_rdata is written with pending_pc at wr pointer (unless flushed this cycle).
- Pop: inst_valid && inst_ready advances rd pointer. Push and pop in the same cycle leave count unchanged.
- Pop credit is not used for issue: a full-minus-pending queue stalls issue even if decode pops that cycle.
- inst_word/inst_pc show the head entry whenever count>0; value when invalid is don't-care except after reset (0).
- Pointers wrap modulo DEPTH; count never exceeds DEPTH (guaranteed by issue rule; overflow is a design error flagged by an assertion).

## Timing
- Reset values: pc_counter=00, imem_req=0, inst_valid=0, inst_word=0, inst_pc=0, q_count=0, pending=0.
- First cycle after reset release: imem_req=1, imem_addr=0, pc_counter=01.
- Fetch latency PC-to-inst_valid: 2 cycles (issue cycle N, data N+1 written, visible N+2).
- Steady state with inst_ready=1: one instruction per cycle.
- First valid instruction after redirect/restart: 3 cycles after the redirect cycle (load, issue, data, visible).
- Response arriving in a redirect/restart cycle is discarded.
- rst asserted mid-operation: all state clears immediately (asynchronously); in-flight data is never written.

## Configuration
- FETCH_BYPASS_EN defined: when count=0 and a response arrives, inst_valid=1 with imem_rdata/pending_pc combinationally in the arrival cycle; if inst_ready=1 the word is consumed and not written; otherwise written normally. Latency becomes 1 cycle; post-redirect latency 2.
- Undefined: all responses go through the queue; latency as in Timing.

## Test plan
- Reset, inst_ready=1, imem returns addr+16'h1000: inst_valid rises 2 cycles after first req; inst_pc 0,1,2,... words 1000,1001,... one per cycle.
- inst_ready=0 from start, DEPTH=4: exactly 4 reads issued, q_count=4, then pc_counter=00, imem_req=0, pc_out holds 4; raising inst_ready drains 0..3 in order and resumes fetch at 4.
- Redirect to 16'h0040 while 3 entries queued and one read pending: next cycle q_count=0, pending response dropped, pc_counter=10 in that cycle, first new inst_pc=0x0040.
- Simultaneous restart and redirect: pc_counter=11, first fetched inst_pc=0.
- rst pulsed mid-stream between clock edges: outputs drop to reset values without a clock edge; fetch resumes from PC 0.
- With FETCH_BYPASS_EN: empty queue, inst_ready=1: inst_valid in the response cycle, q_count stays 0.
